// File: rtl/rf_bank_req_queue_pkg.sv
// Shared types and constants for the register-file bank request queue.
// Entry layout is {slot, ocid, row}; slot 0 = source 1, slot 1 = source 2.
package rfq_pkg;

    localparam int DEPTH_DEF         = 8;
    localparam int ROW_W_DEF         = 3;
    localparam int OCID_W_DEF        = 3;
    localparam int DATA_W_DEF        = 256;
    localparam int MAX_WR_STREAK_DEF = 4;

    localparam int PTR_W = $clog2(DEPTH_DEF) + 1;

    localparam logic SLOT_SRC1 = 1'b0;
    localparam logic SLOT_SRC2 = 1'b1;

    typedef struct packed {
        logic                  slot;
        logic [OCID_W_DEF-1:0] ocid;
        logic [ROW_W_DEF-1:0]  row;
    } entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int entry_w(input int ocid_w, input int row_w);
        return 1 + ocid_w + row_w;
    endfunction

endpackage

// File: rtl/rf_bank_req_queue_if.sv
// Bundle of OC push, CDB write, bank and response signals for rf_bank_req_queue.
// master = OC/CDB/bank side, slave = the queue itself.
interface rf_bank_req_queue_if #(
    parameter int DEPTH  = 8,
    parameter int ROW_W  = 3,
    parameter int OCID_W = 3,
    parameter int DATA_W = 256
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic              push_two;
    logic [ROW_W-1:0]  src1_row;
    logic [OCID_W-1:0] src1_ocid;
    logic [ROW_W-1:0]  src2_row;
    logic [OCID_W-1:0] src2_ocid;
    logic              push_ready;
    logic              wr_valid;
    logic [ROW_W-1:0]  wr_row;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ROW_W-1:0]  rf_addr;
    logic              rf_wr;
    logic              rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              rsp_valid;
    logic [OCID_W-1:0] rsp_ocid;
    logic              rsp_slot;
    logic [PW-1:0]     count;
    logic              full;
    logic              empty;

    modport master (
        output push_valid, push_two, src1_row, src1_ocid, src2_row, src2_ocid,
               wr_valid, wr_row, wr_data,
        input  push_ready, wr_ready, rf_addr, rf_wr, rf_rd, rf_wdata,
               rsp_valid, rsp_ocid, rsp_slot, count, full, empty
    );

    modport slave (
        input  push_valid, push_two, src1_row, src1_ocid, src2_row, src2_ocid,
               wr_valid, wr_row, wr_data,
        output push_ready, wr_ready, rf_addr, rf_wr, rf_rd, rf_wdata,
               rsp_valid, rsp_ocid, rsp_slot, count, full, empty
    );
endinterface

// File: rtl/rf_bank_req_queue_storage.sv
// Queue entry array: two write ports (pair pushes) and one asynchronous read port.
// Entries are deliberately not reset.
module rfq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 7
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [W-1:0]             wdata0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [W-1:0]             wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_r [DEPTH];

    // Entry writes; the two ports never target the same slot.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[waddr0] <= wdata0;
        end
        if (we1) begin
            mem_r[waddr1] <= wdata1;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/rf_bank_req_queue.sv
// Per-bank RF request queue: buffers operand reads, arbitrates against CDB writes.
// Optional read-starvation guard enabled by defining RFQ_WR_STARVE_GUARD_EN.
module rf_bank_req_queue
    import rfq_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEF,
    parameter int ROW_W         = ROW_W_DEF,
    parameter int OCID_W        = OCID_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_WR_STREAK = MAX_WR_STREAK_DEF
) (
    input logic                clk,
    input logic                rst,
    rf_bank_req_queue_if.slave bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int EW = entry_w(OCID_W, ROW_W);

    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     count_s;
    logic [PW-1:0]     wr_ptr_nxt_s;
    logic [PW-1:0]     push_n_s;
    logic              empty_s;
    logic              push_fire_s;
    logic              wr_ready_s;
    logic              wr_cyc_s;
    logic              rd_cyc_s;
    logic [EW-1:0]     ent1_s;
    logic [EW-1:0]     ent2_s;
    logic [EW-1:0]     head_s;
    logic              rsp_valid_r;
    logic              rsp_slot_r;
    logic [OCID_W-1:0] rsp_ocid_r;

    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign empty_s      = (count_s == PW'(0));
    // Two free slots are always required so a pair is never split.
    assign bus.push_ready = (count_s <= PW'(DEPTH - 2));
    assign push_fire_s  = bus.push_valid & bus.push_ready;
    assign wr_ptr_nxt_s = wr_ptr_r + PW'(1);
    assign wr_cyc_s     = bus.wr_valid & wr_ready_s;
    assign rd_cyc_s     = ~wr_cyc_s & ~empty_s;

    assign ent1_s = {SLOT_SRC1, bus.src1_ocid, bus.src1_row};
    assign ent2_s = {SLOT_SRC2, bus.src2_ocid, bus.src2_row};

    rfq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
        .clk    (clk),
        .we0    (push_fire_s),
        .waddr0 (wr_ptr_r[AW-1:0]),
        .wdata0 (ent1_s),
        .we1    (push_fire_s & bus.push_two),
        .waddr1 (wr_ptr_nxt_s[AW-1:0]),
        .wdata1 (ent2_s),
        .raddr  (rd_ptr_r[AW-1:0]),
        .rdata  (head_s)
    );

    // Number of entries added by this cycle's push.
    always_comb begin
        push_n_s = PW'(0);
        if (push_fire_s) begin
            push_n_s = bus.push_two ? PW'(2) : PW'(1);
        end else begin
            push_n_s = PW'(0);
        end
    end

    // Queue pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            wr_ptr_r <= wr_ptr_r + push_n_s;
            rd_ptr_r <= rd_ptr_r + (rd_cyc_s ? PW'(1) : PW'(0));
        end
    end

`ifdef RFQ_WR_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_WR_STREAK + 1);
    logic [SW-1:0] streak_r;

    assign wr_ready_s = (streak_r != SW'(MAX_WR_STREAK));

    // Consecutive write cycles seen while reads are waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_r <= SW'(0);
        end else if (empty_s || !wr_cyc_s) begin
            streak_r <= SW'(0);
        end else begin
            streak_r <= streak_r + SW'(1);
        end
    end
`else
    assign wr_ready_s = 1'b1;
`endif

    // Bank port arbitration: CDB write wins, otherwise pop the head.
    always_comb begin
        bus.rf_wr   = 1'b0;
        bus.rf_rd   = 1'b0;
        bus.rf_addr = ROW_W'(0);
        if (wr_cyc_s) begin
            bus.rf_wr   = 1'b1;
            bus.rf_addr = bus.wr_row;
        end else if (!empty_s) begin
            bus.rf_rd   = 1'b1;
            bus.rf_addr = head_s[ROW_W-1:0];
        end else begin
            bus.rf_addr = ROW_W'(0);
        end
    end

    // Response tag lines up with bank read data one cycle after rf_rd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_ocid_r  <= OCID_W'(0);
            rsp_slot_r  <= 1'b0;
        end else begin
            rsp_valid_r <= rd_cyc_s;
            rsp_ocid_r  <= head_s[ROW_W +: OCID_W];
            rsp_slot_r  <= head_s[EW-1];
        end
    end

    assign bus.wr_ready  = wr_ready_s;
    assign bus.rf_wdata  = bus.wr_data;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_ocid  = rsp_ocid_r;
    assign bus.rsp_slot  = rsp_slot_r;
    assign bus.count     = count_s;
    assign bus.empty     = empty_s;
    assign bus.full      = (count_s == PW'(DEPTH));
endmodule

// File: tb/tb_rf_bank_req_queue.sv
// Directed self-checking bench for rf_bank_req_queue (default DEPTH=8 build).
module tb_rf_bank_req_queue;
    import rfq_pkg::*;

    localparam int DEPTH         = 8;
    localparam int ROW_W         = 3;
    localparam int OCID_W        = 3;
    localparam int DATA_W        = 256;
    localparam int MAX_WR_STREAK = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rf_bank_req_queue_if #(.DEPTH(DEPTH), .ROW_W(ROW_W), .OCID_W(OCID_W), .DATA_W(DATA_W)) bus ();

    rf_bank_req_queue #(
        .DEPTH(DEPTH), .ROW_W(ROW_W), .OCID_W(OCID_W), .DATA_W(DATA_W), .MAX_WR_STREAK(MAX_WR_STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_valid = 1'b0;
        bus.push_two   = 1'b0;
        bus.src1_row   = '0;
        bus.src1_ocid  = '0;
        bus.src2_row   = '0;
        bus.src2_ocid  = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_row     = '0;
        bus.wr_data    = {4{64'hA5A5_5A5A_0123_4567}};
    endtask

    task automatic push_pair(input int r1, input int o1, input int r2, input int o2);
        bus.push_valid = 1'b1;
        bus.push_two   = 1'b1;
        bus.src1_row   = ROW_W'(r1);
        bus.src1_ocid  = OCID_W'(o1);
        bus.src2_row   = ROW_W'(r2);
        bus.src2_ocid  = OCID_W'(o2);
    endtask

    task automatic drain();
        idle_inputs();
        settle();
        for (int i = 0; i < 40; i++) begin
            if (bus.empty && !bus.rsp_valid) break;
            step();
        end
        check("drain_empty", 64'(bus.empty), 64'd1);
    endtask

    entry_t      mq[$];
    entry_t      last_e;
    bit          last_v;
    bit          exp_ready;
    int          pushed;
    logic [PTR_W-1:0] exp_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_push_ready", 64'(bus.push_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b1;
        step();

        // Pair push into empty queue: reads on +1/+2, responses on +2/+3
        push_pair(2, 5, 6, 5);
        settle();
        check("t1_ready", 64'(bus.push_ready), 64'd1);
        check("t1_rd0", 64'(bus.rf_rd), 64'd0);
        step();
        idle_inputs();
        settle();
        check("t1_rd1", 64'(bus.rf_rd), 64'd1);
        check("t1_addr1", 64'(bus.rf_addr), 64'd2);
        check("t1_count1", 64'(bus.count), 64'd2);
        check("t1_rsp1", 64'(bus.rsp_valid), 64'd0);
        step();
        check("t1_rd2", 64'(bus.rf_rd), 64'd1);
        check("t1_addr2", 64'(bus.rf_addr), 64'd6);
        check("t1_rsp2", 64'(bus.rsp_valid), 64'd1);
        check("t1_slot2", 64'(bus.rsp_slot), 64'd0);
        check("t1_ocid2", 64'(bus.rsp_ocid), 64'd5);
        step();
        check("t1_rd3", 64'(bus.rf_rd), 64'd0);
        check("t1_rsp3", 64'(bus.rsp_valid), 64'd1);
        check("t1_slot3", 64'(bus.rsp_slot), 64'd1);
        check("t1_ocid3", 64'(bus.rsp_ocid), 64'd5);
        check("t1_empty3", 64'(bus.empty), 64'd1);
        step();
        check("t1_rsp4", 64'(bus.rsp_valid), 64'd0);

`ifndef RFQ_WR_STARVE_GUARD_EN
        // Fill with writes blocking the bank: last slot stays reserved
        bus.wr_valid = 1'b1;
        bus.wr_row   = 3'd0;
        push_pair(1, 1, 2, 2);
        settle();
        check("fill_rf_wr", 64'(bus.rf_wr), 64'd1);
        check("fill_rf_rd", 64'(bus.rf_rd), 64'd0);
        check("fill_wdata", bus.rf_wdata[63:0], 64'hA5A5_5A5A_0123_4567);
        step();
        push_pair(3, 3, 4, 4);
        step();
        push_pair(5, 5, 6, 6);
        step();
        bus.push_two = 1'b0;
        bus.src1_row = 3'd7;
        settle();
        check("fill_count6", 64'(bus.count), 64'd6);
        check("fill_ready6", 64'(bus.push_ready), 64'd1);
        step();
        check("fill_count7", 64'(bus.count), 64'd7);
        check("fill_ready7", 64'(bus.push_ready), 64'd0);
        check("fill_full7", 64'(bus.full), 64'd0);
        step();
        check("fill_drop", 64'(bus.count), 64'd7);
        idle_inputs();
        settle();
        for (int i = 0; i < 7; i++) begin
            check("fill_order", 64'(bus.rf_addr), 64'(i + 1));
            step();
        end
        check("fill_empty", 64'(bus.empty), 64'd1);
`endif
        drain();

        // Write priority at count=2
        push_pair(2, 1, 5, 1);
        bus.wr_valid = 1'b1;
        bus.wr_row   = 3'd4;
        settle();
        step();
        bus.push_valid = 1'b0;
        settle();
        check("wp_count", 64'(bus.count), 64'd2);
        check("wp_rf_wr", 64'(bus.rf_wr), 64'd1);
        check("wp_addr", 64'(bus.rf_addr), 64'd4);
        check("wp_rf_rd", 64'(bus.rf_rd), 64'd0);
        step();
        check("wp_count_hold", 64'(bus.count), 64'd2);
        bus.wr_valid = 1'b0;
        settle();
        check("wp_rd_head", 64'(bus.rf_rd), 64'd1);
        check("wp_head_addr", 64'(bus.rf_addr), 64'd2);
        check("wp_rf_wr_off", 64'(bus.rf_wr), 64'd0);
        step();
        check("wp_count_pop", 64'(bus.count), 64'd1);

        // Raise to count=3, then push pair while popping
        bus.wr_valid = 1'b1;
        push_pair(0, 2, 1, 2);
        settle();
        step();
        bus.wr_valid = 1'b0;
        push_pair(2, 3, 3, 3);
        settle();
        check("pp_count3", 64'(bus.count), 64'd3);
        check("pp_rd", 64'(bus.rf_rd), 64'd1);
        check("pp_addr", 64'(bus.rf_addr), 64'd5);
        check("pp_ready", 64'(bus.push_ready), 64'd1);
        step();
        idle_inputs();
        settle();
        check("pp_count4", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("pp_order", 64'(bus.rf_addr), 64'(i));
            step();
        end
        drain();

        // Scoreboard run: 20 push operations, pointers wrap
        mq.delete();
        last_v = 1'b0;
        pushed = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (pushed >= 20 && mq.size() == 0 && !last_v) break;
            if (pushed < 20) begin
                push_pair(pushed, pushed * 3, pushed + 4, pushed * 5 + 1);
                bus.push_two = ((pushed % 2) == 1);
            end else begin
                bus.push_valid = 1'b0;
            end
            settle();
            exp_ready = ((DEPTH - mq.size()) >= 2);
            check("sb_ready", 64'(bus.push_ready), 64'(exp_ready));
            check("sb_rsp_valid", 64'(bus.rsp_valid), 64'(last_v));
            if (last_v) begin
                check("sb_rsp_ocid", 64'(bus.rsp_ocid), 64'(last_e.ocid));
                check("sb_rsp_slot", 64'(bus.rsp_slot), 64'(last_e.slot));
            end
            if (mq.size() > 0) begin
                check("sb_rd", 64'(bus.rf_rd), 64'd1);
                check("sb_addr", 64'(bus.rf_addr), 64'(mq[0].row));
                last_e = mq.pop_front();
                last_v = 1'b1;
            end else begin
                check("sb_idle", 64'(bus.rf_rd), 64'd0);
                last_v = 1'b0;
            end
            if (bus.push_valid && exp_ready) begin
                mq.push_back('{SLOT_SRC1, OCID_W'(pushed * 3), ROW_W'(pushed)});
                if (bus.push_two) begin
                    mq.push_back('{SLOT_SRC2, OCID_W'(pushed * 5 + 1), ROW_W'(pushed + 4)});
                end
                pushed++;
            end
            step();
        end
        check("sb_pushed", 64'(pushed), 64'd20);
        check("sb_model_empty", 64'(mq.size()), 64'd0);
        drain();

`ifdef RFQ_WR_STARVE_GUARD_EN
        // Starvation guard: 4 writes, one forced read, writes resume
        push_pair(1, 1, 2, 2);
        bus.wr_valid = 1'b1;
        bus.wr_row   = 3'd7;
        settle();
        step();
        bus.push_valid = 1'b0;
        settle();
        for (int k = 0; k < MAX_WR_STREAK; k++) begin
            check("sg_wr_ready", 64'(bus.wr_ready), 64'd1);
            check("sg_rf_wr", 64'(bus.rf_wr), 64'd1);
            step();
        end
        check("sg_blocked", 64'(bus.wr_ready), 64'd0);
        check("sg_forced_rd", 64'(bus.rf_rd), 64'd1);
        check("sg_forced_addr", 64'(bus.rf_addr), 64'd1);
        step();
        check("sg_resume_ready", 64'(bus.wr_ready), 64'd1);
        check("sg_resume_wr", 64'(bus.rf_wr), 64'd1);
        drain();
`endif

        // Mid-operation reset with count=5 and a response in flight
        exp_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            push_pair(i, i, i + 4, i);
            step();
        end
        idle_inputs();
        settle();
        exp_cnt = PTR_W'(5);
        check("mr_count5", 64'(bus.count), 64'(exp_cnt));
        check("mr_rsp_pending", 64'(bus.rsp_valid), 64'd1);
        rst = 1'b0;
        step();
        check("mr_count0", 64'(bus.count), 64'd0);
        check("mr_empty", 64'(bus.empty), 64'd1);
        check("mr_rsp_clear", 64'(bus.rsp_valid), 64'd0);
        check("mr_ready", 64'(bus.push_ready), 64'd1);
        rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
